// File: rtl/coin_input_cond.sv
// Coin-key front end: synchronises, debounces and edge-detects two raw coin keys and
// issues mutually exclusive, spaced single-cycle coin pulses to the vend FSM.
module coin_input_cond #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned GAP_CYCLES      = 16,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_coin5,
    input  logic       key_coin10,
    output logic       have_coin5,
    output logic       have_coin10,
    output logic [1:0] key_level,
    output logic [7:0] drop_cnt
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [GW-1:0] GAP_ZERO = GW'(0);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

    logic [1:0]    raw_s;
    logic [1:0]    sync1_r;
    logic [1:0]    sync2_r;
    logic [CW-1:0] cnt_r [2];
    logic [1:0]    level_r;
    logic [1:0]    level_d_r;
    logic [1:0]    press_s;
    logic [1:0]    pend_r;
    logic [1:0]    pend_nxt_s;
    logic [1:0]    issue_s;
    logic [1:0]    drop_s;
    logic [GW-1:0] gcnt_r;
    logic [1:0]    have_r;
    logic [7:0]    drop_cnt_r;
    logic [8:0]    drop_sum_s;

    // Bit 1 = coin10, bit 0 = coin5; normalised so that 1 always means pressed.
    assign raw_s = KEY_ACTIVE_LOW ? ~{key_coin10, key_coin5} : {key_coin10, key_coin5};

    // Two-flop synchroniser for the asynchronous keys.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: a differing synced level must persist DEBOUNCE_CYCLES edges; any match restarts.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            level_r   <= 2'b00;
            level_d_r <= 2'b00;
            for (int ch = 0; ch < 2; ch++) begin
                cnt_r[ch] <= CNT_ZERO;
            end
        end else begin
            level_d_r <= level_r;
            for (int ch = 0; ch < 2; ch++) begin
                if (sync2_r[ch] == level_r[ch]) begin
                    cnt_r[ch] <= CNT_ZERO;
                end else if (cnt_r[ch] == CNT_LAST) begin
                    level_r[ch] <= sync2_r[ch];
                    cnt_r[ch]   <= CNT_ZERO;
                end else begin
                    cnt_r[ch] <= cnt_r[ch] + CNT_ONE;
                end
            end
        end
    end

    assign press_s = level_r & ~level_d_r;

    // Arbiter: coin5 has priority, nothing issues while the gap counter runs.
    always_comb begin
        issue_s = 2'b00;
        if (gcnt_r != GAP_ZERO) begin
            issue_s = 2'b00;
        end else if (pend_r[0]) begin
            issue_s = 2'b01;
        end else if (pend_r[1]) begin
            issue_s = 2'b10;
        end else begin
            issue_s = 2'b00;
        end
    end

    // A press landing on the cycle its pending flag is consumed re-arms it instead of dropping.
    assign pend_nxt_s = (pend_r & ~issue_s) | press_s;
    assign drop_s     = press_s & pend_r & ~issue_s;
    assign drop_sum_s = {1'b0, drop_cnt_r} + {8'h00, drop_s[0]} + {8'h00, drop_s[1]};

    // Pending flags, gap counter, pulse and saturating drop counter registers.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            pend_r     <= 2'b00;
            gcnt_r     <= GAP_ZERO;
            have_r     <= 2'b00;
            drop_cnt_r <= 8'h00;
        end else begin
            pend_r <= pend_nxt_s;
            have_r <= issue_s;
            if (issue_s != 2'b00) begin
                gcnt_r <= GAP_LOAD;
            end else if (gcnt_r != GAP_ZERO) begin
                gcnt_r <= gcnt_r - GAP_ONE;
            end else begin
                gcnt_r <= GAP_ZERO;
            end
            if (drop_sum_s > 9'd255) begin
                drop_cnt_r <= 8'hFF;
            end else begin
                drop_cnt_r <= drop_sum_s[7:0];
            end
        end
    end

    assign have_coin5  = have_r[0];
    assign have_coin10 = have_r[1];
    assign key_level   = level_r;
    assign drop_cnt    = drop_cnt_r;

endmodule

// File: tb/tb_coin_input_cond.sv
// Bench for coin_input_cond: directed scenarios plus random key activity, checked every cycle
// against a window/timestamp based reference model for two differently parameterised instances.
module tb_coin_input_cond;

    localparam int D_A = 4;
    localparam int G_A = 3;
    localparam int D_B = 2;
    localparam int G_B = 12;

    logic       sys_clk    = 1'b0;
    logic       sys_rst_n  = 1'b0;
    logic       key_coin5  = 1'b1;
    logic       key_coin10 = 1'b1;
    logic       have5_a, have10_a, have5_b, have10_b;
    logic [1:0] lvl_a, lvl_b;
    logic [7:0] drop_a, drop_b;

    int n_assert = 0;
    int n_fail   = 0;

    coin_input_cond #(.DEBOUNCE_CYCLES(D_A), .GAP_CYCLES(G_A), .KEY_ACTIVE_LOW(1'b1)) u_dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .key_coin5  (key_coin5),
        .key_coin10 (key_coin10),
        .have_coin5 (have5_a),
        .have_coin10(have10_a),
        .key_level  (lvl_a),
        .drop_cnt   (drop_a)
    );

    // Active-high variant with short debounce and long gap, so drops actually happen.
    coin_input_cond #(.DEBOUNCE_CYCLES(D_B), .GAP_CYCLES(G_B), .KEY_ACTIVE_LOW(1'b0)) u_dut_b (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .key_coin5  (~key_coin5),
        .key_coin10 (~key_coin10),
        .have_coin5 (have5_b),
        .have_coin10(have10_b),
        .key_level  (lvl_b),
        .drop_cnt   (drop_b)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model state: pressed-level sample history shared by both instances.
    bit       hist [2][16];
    int       hvalid;
    bit [1:0] m_lvl  [2];
    bit [1:0] m_rose [2];
    bit [1:0] m_pend [2];
    bit [1:0] m_have [2];
    int       m_last [2];
    int       m_drop [2];
    int       edge_no = 0;
    int       dpar [2] = '{D_A, D_B};
    int       gpar [2] = '{G_A, G_B};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // A level is accepted once the last D synced samples (raw delayed two edges) all oppose it;
    // a pulse may issue once more than G edges have passed since the previous pulse.
    task automatic model_edge();
        bit [1:0] raw;
        bit [1:0] iss;
        bit       stable;
        raw = {~key_coin10, ~key_coin5};
        if (!sys_rst_n) begin
            for (int c = 0; c < 2; c++)
                for (int j = 0; j < 16; j++) hist[c][j] = 1'b0;
            hvalid = 2;
            for (int k = 0; k < 2; k++) begin
                m_lvl[k] = 2'b00; m_rose[k] = 2'b00; m_pend[k] = 2'b00; m_have[k] = 2'b00;
                m_last[k] = -1000; m_drop[k] = 0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                for (int j = 15; j > 0; j--) hist[c][j] = hist[c][j-1];
                hist[c][0] = raw[c];
            end
            if (hvalid < 16) hvalid++;
            for (int k = 0; k < 2; k++) begin
                iss = 2'b00;
                if (edge_no - m_last[k] >= gpar[k] + 1) begin
                    if (m_pend[k][0]) iss = 2'b01;
                    else if (m_pend[k][1]) iss = 2'b10;
                end
                if (iss != 2'b00) m_last[k] = edge_no;
                for (int c = 0; c < 2; c++)
                    if (m_rose[k][c] && m_pend[k][c] && !iss[c] && m_drop[k] < 255) m_drop[k]++;
                m_pend[k] = (m_pend[k] & ~iss) | m_rose[k];
                m_have[k] = iss;
                for (int c = 0; c < 2; c++) begin
                    stable = (hvalid >= dpar[k] + 2);
                    for (int i = 0; i < dpar[k]; i++)
                        if (hist[c][2+i] == m_lvl[k][c]) stable = 1'b0;
                    m_rose[k][c] = stable && !m_lvl[k][c];
                    if (stable) m_lvl[k][c] = ~m_lvl[k][c];
                end
            end
        end
        edge_no++;
    endtask

    task automatic check_all();
        chk("have5_a",  have5_a,  m_have[0][0]);
        chk("have10_a", have10_a, m_have[0][1]);
        chk("level_a",  lvl_a,    m_lvl[0]);
        chk("drop_a",   drop_a,   m_drop[0]);
        chk("excl_a",   have5_a & have10_a, 0);
        chk("have5_b",  have5_b,  m_have[1][0]);
        chk("have10_b", have10_b, m_have[1][1]);
        chk("level_b",  lvl_b,    m_lvl[1]);
        chk("drop_b",   drop_b,   m_drop[1]);
        chk("excl_b",   have5_b & have10_b, 0);
    endtask

    task automatic cyc();
        @(posedge sys_clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    int n5, n10, at5, at10, np, d0, last, minsp;
    int hold5, hold10;

    initial begin
        // Reset state
        cyc(); cyc();
        chk("rst_level", lvl_a, 2'b00);
        chk("rst_drop",  drop_a, 8'd0);
        chk("rst_have",  {have10_a, have5_a}, 2'b00);
        sys_rst_n = 1'b1;
        idle(5);

        // Clean coin5 press: one pulse 8 edges after the change
        key_coin5 = 1'b0; n5 = 0; n10 = 0; at5 = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (have5_a) begin n5++; at5 = k; end
            if (have10_a) n10++;
        end
        chk("t1_count", n5, 1);
        chk("t1_edge", at5, 8);
        chk("t1_no10", n10, 0);
        key_coin5 = 1'b1;
        idle(15);

        // Bouncing coin10: only the final settle counts
        n10 = 0; at10 = 0;
        for (int k = 1; k <= 30; k++) begin
            if (k <= 10) key_coin10 = (((k - 1) % 4) < 2) ? 1'b0 : 1'b1;
            cyc();
            if (have10_a) begin n10++; at10 = k; end
        end
        chk("t2_count", n10, 1);
        chk("t2_edge", at10, 16);
        key_coin10 = 1'b1;
        idle(15);

        // Simultaneous presses: coin5 first, coin10 GAP+1 later
        key_coin5 = 1'b0; key_coin10 = 1'b0; n5 = 0; n10 = 0; at5 = 0; at10 = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (have5_a) begin n5++; at5 = k; end
            if (have10_a) begin n10++; at10 = k; end
        end
        chk("t3_edge5", at5, 8);
        chk("t3_edge10", at10, 12);
        chk("t3_counts", n5 + n10, 2);
        key_coin5 = 1'b1; key_coin10 = 1'b1;
        idle(15);

        // Five repeated coin5 presses
        d0 = drop_a; np = 0; last = -100; minsp = 1000;
        for (int k = 0; k < 75; k++) begin
            key_coin5 = (k < 60 && (k % 12) < 6) ? 1'b0 : 1'b1;
            cyc();
            if (have5_a) begin
                if (k - last < minsp) minsp = k - last;
                last = k; np++;
            end
        end
        chk("t4_sum", np + int'(drop_a) - d0, 5);
        chk("t4_spacing", (minsp >= 4) ? 1 : 0, 1);

        // Reset while coin10 is pending and the gap is running
        key_coin5 = 1'b0; key_coin10 = 1'b0;
        idle(7);
        cyc();
        chk("t5_pre", have5_a, 1'b1);
        key_coin5 = 1'b1; key_coin10 = 1'b1; sys_rst_n = 1'b0;
        cyc();
        chk("t5_have", {have10_a, have5_a}, 2'b00);
        chk("t5_level", lvl_a, 2'b00);
        chk("t5_drop", drop_a, 8'd0);
        sys_rst_n = 1'b1; n5 = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (have5_a || have10_a) n5++;
        end
        chk("t5_stale", n5, 0);

        // Key held across reset release
        key_coin10 = 1'b0;
        idle(12);
        sys_rst_n = 1'b0;
        cyc();
        chk("t6_level", lvl_a, 2'b00);
        sys_rst_n = 1'b1; n10 = 0; at10 = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (have10_a) begin n10++; at10 = k; end
        end
        chk("t6_count", n10, 1);
        chk("t6_edge", at10, 8);
        key_coin10 = 1'b1; n10 = 0;
        for (int k = 0; k < 15; k++) begin
            cyc();
            if (have10_a) n10++;
        end
        chk("t6_release", n10, 0);

        // Random key activity with occasional resets
        hold5 = 0; hold10 = 0;
        for (int k = 0; k < 1500; k++) begin
            if (hold5 == 0) begin
                key_coin5 = 1'($urandom_range(0, 1));
                hold5 = $urandom_range(1, 9);
            end else hold5--;
            if (hold10 == 0) begin
                key_coin10 = 1'($urandom_range(0, 1));
                hold10 = $urandom_range(1, 9);
            end else hold10--;
            sys_rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            cyc();
        end
        sys_rst_n = 1'b1;

        // Fast coin5 presses overrun the long-gap instance until its drop counter saturates
        key_coin10 = 1'b1;
        for (int k = 0; k < 1600; k++) begin
            key_coin5 = ((k % 4) < 2) ? 1'b0 : 1'b1;
            cyc();
        end
        chk("sat_drop_b", drop_b, 8'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
